// File: rtl/score_draw_ctrl_if.sv
// Score-draw bus: raster/score controls in, ROM and palette hookups, and the
// drawn pixel out.
//   master : raster source / ROM / palette side (drives DrawX/DrawY, score pulses,
//            rom_data and pal_*; observes rom_addr, pal_index, pixel and score)
//   slave  : score_draw_ctrl side
interface score_draw_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned ADDR_W     = 12
);
    logic                    frame_start;
    logic                    score_inc;
    logic                    score_clr;
    logic [9:0]              DrawX;
    logic [9:0]              DrawY;
    logic [ADDR_W-1:0]       rom_addr;
    logic [3:0]              rom_data;
    logic [3:0]              pal_index;
    logic [3:0]              pal_red;
    logic [3:0]              pal_green;
    logic [3:0]              pal_blue;
    logic                    pixel_on;
    logic [3:0]              red;
    logic [3:0]              green;
    logic [3:0]              blue;
    logic [4*NUM_DIGITS-1:0] score_bcd;

    modport master (
        output frame_start, score_inc, score_clr, DrawX, DrawY,
        output rom_data, pal_red, pal_green, pal_blue,
        input  rom_addr, pal_index, pixel_on, red, green, blue, score_bcd
    );

    modport slave (
        input  frame_start, score_inc, score_clr, DrawX, DrawY,
        input  rom_data, pal_red, pal_green, pal_blue,
        output rom_addr, pal_index, pixel_on, red, green, blue, score_bcd
    );
endinterface

// File: rtl/score_draw_ctrl.sv
// score_draw_ctrl: BCD score counter plus a 3-stage streaming pipeline that
// draws the score from a shared digit-sprite ROM and a combinational palette.
//   Clk, Reset        : pixel clock, synchronous active-high reset
//   bus.frame_start   : snapshot the live score for the coming frame
//   bus.score_inc/clr : saturating BCD increment / clear (clear wins)
//   bus.DrawX/DrawY   : raster position (pixel n)
//   bus.rom_addr      : sprite ROM address for pixel n, valid at n+1
//   bus.rom_data      : ROM palette index, valid at n+2
//   bus.pal_index     : rom_data passed straight to the palette
//   bus.pal_*         : palette colour for pal_index
//   bus.pixel_on/rgb  : score pixel for pixel n, valid at n+3
//   bus.score_bcd     : live score, most significant digit in the top nibble
module score_draw_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIGIT_W    = 16,
    parameter int unsigned DIGIT_H    = 16,
    parameter int unsigned X0         = 16,
    parameter int unsigned Y0         = 8,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned TRANSP_IDX = 0,
    parameter int unsigned LZ_BLANK   = 1
) (
    input logic              Clk,
    input logic              Reset,
    score_draw_ctrl_if.slave bus
);

    localparam int unsigned COL_W     = $clog2(DIGIT_W);
    localparam int unsigned ROW_W     = $clog2(DIGIT_H);
    localparam int unsigned SLOT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SPRITE_SZ = DIGIT_W * DIGIT_H;
    localparam logic [10:0] BOX_W     = 11'(NUM_DIGITS * DIGIT_W);
    localparam logic [10:0] BOX_H     = 11'(DIGIT_H);

    typedef logic [NUM_DIGITS-1:0][3:0] bcd_t;

    // State
    bcd_t              live_q, live_d;
    bcd_t              snap_q, snap_d;
    logic              hit1_q, hit1_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              hit2_q, hit2_d;
    logic              pixel_on_q, pixel_on_d;
    logic [3:0]        red_q, red_d;
    logic [3:0]        green_q, green_d;
    logic [3:0]        blue_q, blue_d;

    // Stage-1 geometry
    logic signed [10:0]    dx, dy;
    logic [10:0]           dx_u, dy_u;
    logic                  in_box;
    logic [SLOT_W-1:0]     slot;
    logic [SLOT_W-1:0]     didx;
    logic [3:0]            dval;
    logic [NUM_DIGITS-1:0] blank;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic                  opaque;

    // Live score: clear, or saturating BCD increment rippled through all digits.
    always_comb begin
        logic all_nines;
        logic carry;
        live_d    = live_q;
        all_nines = 1'b1;
        carry     = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (live_q[i] != 4'd9) all_nines = 1'b0;
        end
        if (bus.score_clr) begin
            live_d = '0;
        end else if (bus.score_inc && !all_nines) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (carry) begin
                    if (live_q[i] == 4'd9) begin
                        live_d[i] = 4'd0;
                    end else begin
                        live_d[i] = live_q[i] + 4'd1;
                        carry     = 1'b0;
                    end
                end
            end
        end
        // Snapshot takes the pre-update value when an update coincides.
        snap_d = bus.frame_start ? live_q : snap_q;
    end

    // Stage 1: box test, digit select, leading-zero blank, ROM address.
    always_comb begin
        logic zeros_above;
        // Signed 11-bit offsets so positions left of/above the box go negative.
        dx   = signed'({1'b0, bus.DrawX}) - signed'(11'(X0));
        dy   = signed'({1'b0, bus.DrawY}) - signed'(11'(Y0));
        dx_u = unsigned'(dx);
        dy_u = unsigned'(dy);
        in_box = !dx[10] && !dy[10] && (dx_u < BOX_W) && (dy_u < BOX_H);

        // Screen slot 0 is leftmost and shows the most significant digit.
        slot = SLOT_W'(dx_u >> COL_W);
        didx = SLOT_W'(NUM_DIGITS - 1) - slot;
        dval = snap_q[didx];
        col  = dx_u[COL_W-1:0];
        row  = dy_u[ROW_W-1:0];

        // A digit blanks when it and every more significant digit are zero.
        zeros_above = 1'b1;
        blank       = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zeros_above = zeros_above && (snap_q[i] == 4'd0);
            blank[i]    = (LZ_BLANK != 0) && (i != 0) && zeros_above;
        end

        hit1_d     = in_box && !blank[didx];
        rom_addr_d = '0;
        if (hit1_d) begin
            rom_addr_d = (ADDR_W'(dval) * ADDR_W'(SPRITE_SZ))
                       + (ADDR_W'(row) << COL_W)
                       + ADDR_W'(col);
        end
    end

    // Stages 2/3: hit delayed alongside the ROM read, then colour registered.
    always_comb begin
        hit2_d     = hit1_q;
        opaque     = hit2_q && (bus.rom_data != 4'(TRANSP_IDX));
        pixel_on_d = opaque;
        red_d      = opaque ? bus.pal_red   : 4'd0;
        green_d    = opaque ? bus.pal_green : 4'd0;
        blue_d     = opaque ? bus.pal_blue  : 4'd0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            live_q     <= '0;
            snap_q     <= '0;
            hit1_q     <= 1'b0;
            rom_addr_q <= '0;
            hit2_q     <= 1'b0;
            pixel_on_q <= 1'b0;
            red_q      <= 4'd0;
            green_q    <= 4'd0;
            blue_q     <= 4'd0;
        end else begin
            live_q     <= live_d;
            snap_q     <= snap_d;
            hit1_q     <= hit1_d;
            rom_addr_q <= rom_addr_d;
            hit2_q     <= hit2_d;
            pixel_on_q <= pixel_on_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.pal_index = bus.rom_data;
    assign bus.pixel_on  = pixel_on_q;
    assign bus.red       = red_q;
    assign bus.green     = green_q;
    assign bus.blue      = blue_q;
    assign bus.score_bcd = live_q;

endmodule

// File: tb/tb_score_draw_ctrl.sv
// Bench for score_draw_ctrl: decimal score model, geometric pixel model,
// ROM/palette models, and scoreboard queues for rom_addr (n+1) and pixel (n+3).
module tb_score_draw_ctrl;

    typedef struct packed {
        logic       on;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pix_t;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    score_draw_ctrl_if #(.NUM_DIGITS(4), .ADDR_W(12)) bus ();

    score_draw_ctrl #(
        .NUM_DIGITS(4), .DIGIT_W(16), .DIGIT_H(16), .X0(16), .Y0(8),
        .ADDR_W(12), .TRANSP_IDX(0), .LZ_BLANK(1)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Sprite ROM content: index 1 at address 0, transparent wherever the sum wraps.
    function automatic logic [3:0] rom_func(input logic [11:0] a);
        return 4'(a[3:0] + a[7:4] + a[11:8] + 4'd1);
    endfunction

    // Palette: index 1 is black.
    function automatic logic [3:0] pal_r(input logic [3:0] i);
        return 4'(i - 4'd1);
    endfunction
    function automatic logic [3:0] pal_g(input logic [3:0] i);
        return 4'((i - 4'd1) * 3);
    endfunction
    function automatic logic [3:0] pal_b(input logic [3:0] i);
        return 4'((i - 4'd1) * 5);
    endfunction

    always @(posedge Clk) bus.rom_data <= rom_func(bus.rom_addr);
    assign bus.pal_red   = pal_r(bus.pal_index);
    assign bus.pal_green = pal_g(bus.pal_index);
    assign bus.pal_blue  = pal_b(bus.pal_index);

    int          n_checks;
    int          n_fails;
    int          live_m;
    int          snap_m;
    logic [11:0] addr_q[$];
    pix_t        pix_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Expected ROM address and drawn pixel for raster (x,y) with snapshot `snap`.
    function automatic void model_pixel(input int x, input int y, input int snap,
                                        output logic [11:0] addr, output pix_t px);
        int         pos;
        int         p10;
        int         val;
        logic [3:0] d;
        addr = '0;
        px   = '0;
        if (x < 16 || x > 16 + 64 - 1 || y < 8 || y > 8 + 16 - 1) return;
        pos = 3 - (x - 16) / 16;
        p10 = 1;
        for (int i = 0; i < pos; i++) p10 = p10 * 10;
        val = (snap / p10) % 10;
        if (pos != 0 && snap < p10) return;
        addr = 12'(val * 256 + (y - 8) * 16 + (x - 16) % 16);
        d    = rom_func(addr);
        if (d != 4'd0) begin
            px.on = 1'b1;
            px.r  = pal_r(d);
            px.g  = pal_g(d);
            px.b  = pal_b(d);
        end
    endfunction

    // One clock: compare matured expectations, then drive this cycle's inputs.
    task automatic tick(input int x, input int y, input bit inc, input bit clr,
                        input bit fs, input bit rst);
        logic [11:0] ea;
        pix_t        ep;
        @(negedge Clk);
        if (addr_q.size() > 0) begin
            ea = addr_q.pop_front();
            check("rom_addr", 32'(bus.rom_addr), 32'(ea));
            check("score_bcd", 32'(bus.score_bcd), 32'(to_bcd(live_m)));
        end
        if (pix_q.size() >= 3) begin
            ep = pix_q.pop_front();
            check("pixel_on", 32'(bus.pixel_on), 32'(ep.on));
            check("rgb", 32'({bus.red, bus.green, bus.blue}), 32'({ep.r, ep.g, ep.b}));
        end
        Reset           = rst;
        bus.DrawX       = 10'(x);
        bus.DrawY       = 10'(y);
        bus.score_inc   = inc;
        bus.score_clr   = clr;
        bus.frame_start = fs;
        if (rst) begin
            // Reset drops the pixels still in flight.
            for (int i = 0; i < pix_q.size(); i++) pix_q[i] = '0;
            ea     = '0;
            ep     = '0;
            live_m = 0;
            snap_m = 0;
        end else begin
            model_pixel(x, y, snap_m, ea, ep);
            if (fs) snap_m = live_m;
            if (clr) live_m = 0;
            else if (inc && live_m < 9999) live_m++;
        end
        addr_q.push_back(ea);
        pix_q.push_back(ep);
    endtask

    task automatic scan_row(input int y);
        for (int x = 14; x <= 81; x++) tick(x, y, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks        = 0;
        n_fails         = 0;
        live_m          = 0;
        snap_m          = 0;
        Reset           = 1'b1;
        bus.frame_start = 1'b0;
        bus.score_inc   = 1'b0;
        bus.score_clr   = 1'b0;
        bus.DrawX       = '0;
        bus.DrawY       = '0;

        repeat (3) tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Score 0000: leftmost slot blanked, rightmost "0" drawn.
        tick(16, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(40, 10, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(64, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(79, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(70, 20, 1'b0, 1'b0, 1'b0, 1'b0);

        // 1234 increments, snapshot, then the box and its edges.
        repeat (1234) tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(35, 13, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(15, 13, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(80, 13, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(0, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        scan_row(7);
        scan_row(8);
        scan_row(13);
        scan_row(23);
        scan_row(24);

        // Up to 9998, saturate at 9999, then clear beats increment.
        repeat (9998 - 1234) tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        scan_row(12);
        tick(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 0041 with increment coincident with frame_start.
        repeat (41) tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        scan_row(10);
        tick(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        scan_row(10);

        // Reset while hits are in flight.
        for (int i = 0; i < 6; i++) tick(64 + i, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(70, 9, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tick(64 + i, 9, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random raster positions with occasional score events.
        repeat (400) begin
            tick(int'($urandom_range(0, 100)), int'($urandom_range(0, 30)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 60) == 0),
                 ($urandom_range(0, 15) == 0), 1'b0);
        end

        repeat (4) tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
